dm_stage: RTL

DM_STAGE -- requirements
Module: dm_stage

---
 rtl/dm_stage_if.sv | 41 ++++
 rtl/dm_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/dm_stage_if.sv
// M-to-W data-memory stage bundle: M-side request fields and W-side results.
// Combinational wiring only, so it adds no latency.
// No backpressure: every field is sampled or updated on each clock edge.
// Optional feature macro: DM_ALIGN_CHECK_EN adds the AlignErrW result field.
interface dm_stage_if;
  logic [31:0] pcM;
  logic [5:0]  opcodeM;
  logic [31:0] ALUoutM;
  logic [31:0] WriteDataM;
  logic [4:0]  WriteRegM;
  logic [1:0]  MemtoRegM;
  logic        RegWriteM;
  logic        MemWriteM;
  logic [31:0] ReadDataW;
  logic [31:0] ALUoutW;
  logic [4:0]  WriteRegW;
  logic [1:0]  MemtoRegW;
  logic        RegWriteW;
  logic [31:0] pcW;
`ifdef DM_ALIGN_CHECK_EN
  logic        AlignErrW;
`endif

  // Upstream side: drives the M-stage fields, observes the W-stage results.
  modport master (
`ifdef DM_ALIGN_CHECK_EN
    input  AlignErrW,
`endif
    output pcM, opcodeM, ALUoutM, WriteDataM, WriteRegM, MemtoRegM, RegWriteM, MemWriteM,
    input  ReadDataW, ALUoutW, WriteRegW, MemtoRegW, RegWriteW, pcW
  );

  // Stage side: consumes the M-stage fields, produces the W-stage results.
  modport slave (
`ifdef DM_ALIGN_CHECK_EN
    output AlignErrW,
`endif
    input  pcM, opcodeM, ALUoutM, WriteDataM, WriteRegM, MemtoRegM, RegWriteM, MemWriteM,
    output ReadDataW, ALUoutW, WriteRegW, MemtoRegW, RegWriteW, pcW
  );
endinterface

// File: rtl/dm_stage.sv
// Data-memory stage: 1024x32 little-endian RAM with byte/half/word stores and extended loads.
// Latency: every W output is registered exactly one cycle after its M input.
// No backpressure: no stall or bubble logic; optional DM_ALIGN_CHECK_EN blocks misaligned accesses.
module dm_stage (
  input  logic    clk,
  input  logic    reset_n,
  dm_stage_if.slave bus
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  logic [31:0] mem [0:1023];

  // Upper address bits are dropped so the array aliases every 4 KiB.
  logic [9:0]  word_idx;
  logic [1:0]  byte_off;
  logic [3:0]  wr_be;
  logic [31:0] wr_dat;
  logic        wr_en;
  logic [31:0] rd_word;
  logic [31:0] rd_ext;
  logic        misaligned;

  assign word_idx = bus.ALUoutM[11:2];
  assign byte_off = bus.ALUoutM[1:0];
  assign rd_word  = mem[word_idx];

  // Store lane selection: partial stores replicate data across lanes and enable only the addressed bytes.
  always_comb begin
    wr_be  = 4'hF;
    wr_dat = bus.WriteDataM;
    case (bus.opcodeM)
      OP_SH: begin
        wr_be  = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_dat = {2{bus.WriteDataM[15:0]}};
      end
      OP_SB: begin
        wr_be  = 4'b0001 << byte_off;
        wr_dat = {4{bus.WriteDataM[7:0]}};
      end
      default: begin
        wr_be  = 4'hF;
        wr_dat = bus.WriteDataM;
      end
    endcase
  end

  // Alignment classification: word ops need offset 0, halfword ops need an even offset.
  always_comb begin
    misaligned = 1'b0;
`ifdef DM_ALIGN_CHECK_EN
    if ((bus.opcodeM == OP_LW) || (bus.opcodeM == OP_SW))
      misaligned = (byte_off != 2'b00);
    else if ((bus.opcodeM == OP_LH) || (bus.opcodeM == OP_LHU) || (bus.opcodeM == OP_SH))
      misaligned = byte_off[0];
`endif
  end

  assign wr_en = bus.MemWriteM & ~misaligned;

  // Load extension from the pre-edge array contents.
  always_comb begin
    rd_ext = rd_word;
    case (bus.opcodeM)
      OP_LW:  rd_ext = rd_word;
      OP_LB:  rd_ext = {{24{rd_word[{byte_off, 3'b111}]}}, rd_word[{byte_off, 3'b000} +: 8]};
      OP_LBU: rd_ext = {24'h0, rd_word[{byte_off, 3'b000} +: 8]};
      OP_LH:  rd_ext = byte_off[1] ? {{16{rd_word[31]}}, rd_word[31:16]}
                                   : {{16{rd_word[15]}}, rd_word[15:0]};
      OP_LHU: rd_ext = byte_off[1] ? {16'h0, rd_word[31:16]} : {16'h0, rd_word[15:0]};
      default: rd_ext = rd_word;
    endcase
  end

  // Memory array: reset clears every word and overrides any store in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
    end else if (wr_en) begin
      for (int b = 0; b < 4; b++)
        if (wr_be[b]) mem[word_idx][8*b +: 8] <= wr_dat[8*b +: 8];
    end
  end

  // M-to-W pipeline register; misaligned loads lose their register write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.ReadDataW <= 32'h0;
      bus.ALUoutW   <= 32'h0;
      bus.WriteRegW <= 5'h0;
      bus.MemtoRegW <= 2'h0;
      bus.RegWriteW <= 1'b0;
      bus.pcW       <= 32'h0;
    end else begin
      bus.ReadDataW <= rd_ext;
      bus.ALUoutW   <= bus.ALUoutM;
      bus.WriteRegW <= bus.WriteRegM;
      bus.MemtoRegW <= bus.MemtoRegM;
      bus.RegWriteW <= bus.RegWriteM & ~(misaligned & ~bus.MemWriteM);
      bus.pcW       <= bus.pcM;
    end
  end

`ifdef DM_ALIGN_CHECK_EN
  // Alignment error flag travels with its access into W.
  always_ff @(posedge clk) begin
    if (!reset_n) bus.AlignErrW <= 1'b0;
    else          bus.AlignErrW <= misaligned;
  end
`endif

endmodule
